// File: rtl/halfband_mac_scheduler.sv
// Round-robin scheduler that time-shares one registered MAC slice among NUM_CH half-band channels.
// Define HBF_SCHED_OVRCNT_EN to add per-channel 8-bit saturating overrun counters on ovr_cnt_o.
module halfband_mac_scheduler #(
    parameter int NUM_CH    = 4,
    parameter int NUM_PAIRS = 2,
    parameter int PIPE_LAT  = 2,
    parameter int CH_W      = $clog2(NUM_CH),
    parameter int PH_W      = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic [NUM_CH-1:0]   req_i,
    input  logic                ovr_clr_i,
    output logic [NUM_CH-1:0]   grant_o,
    output logic                grant_vld_o,
    output logic [PH_W-1:0]     phase_o,
    output logic                acc_clr_o,
    output logic                out_vld_o,
    output logic [CH_W-1:0]     out_ch_o,
    output logic [NUM_CH-1:0]   ovr_flag_o
`ifdef HBF_SCHED_OVRCNT_EN
    ,
    output logic [NUM_CH*8-1:0] ovr_cnt_o
`endif
);
    localparam int DR_W = 3;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_DONE} state_e;

    state_e            state_q;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] ovr_flag_q, ovr_flag_d;
    logic [NUM_CH-1:0] grant_q, grant_now, ovr_ev;
    logic [CH_W-1:0]   rr_ptr_q, ch_q, out_ch_q, pick;
    logic [PH_W-1:0]   phase_q;
    logic [DR_W-1:0]   drain_q;
    logic              grant_vld_q, acc_clr_q, out_vld_q;
    logic              found, take;
    int                idx;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        idx   = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_CH;
            if (!found && pending_q[CH_W'(idx)]) begin
                found = 1'b1;
                pick  = CH_W'(idx);
            end
        end
        take      = (state_q == S_IDLE) && found;
        grant_now = '0;
        if (take) grant_now[pick] = 1'b1;
    end

    // A request landing on its own grant edge is a fresh sample, not an overrun.
    assign ovr_ev     = req_i & pending_q & ~grant_now;
    assign pending_d  = (pending_q & ~grant_now) | req_i;
    assign ovr_flag_d = (ovr_clr_i ? '0 : ovr_flag_q) | ovr_ev;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pending_q  <= '0;
            ovr_flag_q <= '0;
        end else begin
            pending_q  <= pending_d;
            ovr_flag_q <= ovr_flag_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            ch_q        <= '0;
            grant_q     <= '0;
            grant_vld_q <= 1'b0;
            phase_q     <= '0;
            acc_clr_q   <= 1'b0;
            out_vld_q   <= 1'b0;
            out_ch_q    <= '0;
            drain_q     <= '0;
        end else begin
            out_vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    phase_q <= '0;
                    if (take) begin
                        state_q     <= S_MAC;
                        grant_q     <= grant_now;
                        grant_vld_q <= 1'b1;
                        acc_clr_q   <= 1'b1;
                        ch_q        <= pick;
                        rr_ptr_q    <= pick;
                    end
                end
                S_MAC: begin
                    acc_clr_q <= 1'b0;
                    if (phase_q == PH_W'(NUM_PAIRS - 1)) begin
                        grant_q     <= '0;
                        grant_vld_q <= 1'b0;
                        phase_q     <= '0;
                        drain_q     <= '0;
                        state_q     <= (PIPE_LAT > 0) ? S_DRAIN : S_DONE;
                        if (PIPE_LAT == 0) begin
                            out_vld_q <= 1'b1;
                            out_ch_q  <= ch_q;
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DR_W'(PIPE_LAT - 1)) begin
                        state_q   <= S_DONE;
                        out_vld_q <= 1'b1;
                        out_ch_q  <= ch_q;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign grant_vld_o = grant_vld_q;
    assign phase_o     = phase_q;
    assign acc_clr_o   = acc_clr_q;
    assign out_vld_o   = out_vld_q;
    assign out_ch_o    = out_ch_q;
    assign ovr_flag_o  = ovr_flag_q;

`ifdef HBF_SCHED_OVRCNT_EN
    logic [7:0] ovr_cnt_q [NUM_CH];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int c = 0; c < NUM_CH; c++) ovr_cnt_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ovr_ev[c]) begin
                    ovr_cnt_q[c] <= ovr_clr_i ? 8'd1 :
                                    (ovr_cnt_q[c] == 8'hFF) ? 8'hFF : ovr_cnt_q[c] + 8'd1;
                end else if (ovr_clr_i) begin
                    ovr_cnt_q[c] <= '0;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_out
        assign ovr_cnt_o[g*8 +: 8] = ovr_cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_halfband_mac_scheduler.sv
// Scoreboard bench for halfband_mac_scheduler: a spec-level timing model queues expected outputs,
// a separate monitor compares DUT outputs every cycle. Honours HBF_SCHED_OVRCNT_EN.
module tb_halfband_mac_scheduler;
    localparam int NUM_CH = 4;
    localparam int NP     = 2;
    localparam int PL     = 2;

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              reset_ni;
    logic [NUM_CH-1:0] req_i;
    logic              ovr_clr_i;
    logic [NUM_CH-1:0] grant_o;
    logic              grant_vld_o;
    logic [0:0]        phase_o;
    logic              acc_clr_o;
    logic              out_vld_o;
    logic [1:0]        out_ch_o;
    logic [NUM_CH-1:0] ovr_flag_o;
`ifdef HBF_SCHED_OVRCNT_EN
    logic [NUM_CH*8-1:0] ovr_cnt_o;
`endif

    halfband_mac_scheduler #(
        .NUM_CH(NUM_CH), .NUM_PAIRS(NP), .PIPE_LAT(PL)
    ) dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .req_i      (req_i),
        .ovr_clr_i  (ovr_clr_i),
        .grant_o    (grant_o),
        .grant_vld_o(grant_vld_o),
        .phase_o    (phase_o),
        .acc_clr_o  (acc_clr_o),
        .out_vld_o  (out_vld_o),
        .out_ch_o   (out_ch_o),
        .ovr_flag_o (ovr_flag_o)
`ifdef HBF_SCHED_OVRCNT_EN
        ,
        .ovr_cnt_o  (ovr_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: edge count since reset release, pending set, flags, rr pointer,
    // the cycle the MAC is free again, and the window of the most recent grant.
    int                cyc       = 0;
    logic [NUM_CH-1:0] m_pend    = '0;
    logic [NUM_CH-1:0] m_flag    = '0;
    int                m_cnt [NUM_CH] = '{default: 0};
    int                m_rr      = 0;
    int                m_free_at = 1;
    int                m_gstart  = -100;
    int                m_gch     = 0;
    exp_t              exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    endtask

    // Model: evaluated on the same edges the DUT samples its inputs.
    initial begin
        logic [NUM_CH-1:0] g, ev;
        int pick;
        forever begin
            @(posedge clk_i or negedge reset_ni);
            if (!reset_ni) begin
                cyc = 0; m_pend = '0; m_flag = '0; m_rr = 0; m_free_at = 1;
                m_gstart = -100; m_gch = 0;
                for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
            end else begin
                cyc++;
                g = '0;
                if (cyc >= m_free_at && m_pend != '0) begin
                    pick = -1;
                    for (int i = 1; i <= NUM_CH; i++)
                        if (pick < 0 && m_pend[(m_rr + i) % NUM_CH]) pick = (m_rr + i) % NUM_CH;
                    g[pick]   = 1'b1;
                    m_rr      = pick;
                    m_gch     = pick;
                    m_gstart  = cyc;
                    m_free_at = cyc + NP + PL + 2;
                    exp_q.push_back('{ch: pick, cyc: cyc + NP + PL});
                end
                ev     = req_i & m_pend & ~g;
                m_flag = (ovr_clr_i ? '0 : m_flag) | ev;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ovr_clr_i) m_cnt[c] = 0;
                    if (ev[c] && m_cnt[c] < 255) m_cnt[c] = m_cnt[c] + 1;
                end
                m_pend = (m_pend & ~g) | req_i;
            end
        end
    end

    // Monitor: compares every cycle, consuming expected strobes from the scoreboard queue.
    initial begin
        int   rd_idx = 0;
        int   last_ch = 0;
        logic exp_vld, gv;
        forever begin
            @(negedge clk_i or negedge reset_ni);
            if (!reset_ni) begin
                rd_idx  = exp_q.size();
                last_ch = 0;
            end else begin
                exp_vld = (rd_idx < exp_q.size()) && (exp_q[rd_idx].cyc == cyc);
                check("out_vld", 32'(out_vld_o), 32'(exp_vld));
                if (exp_vld) begin
                    check("out_ch", 32'(out_ch_o), 32'(exp_q[rd_idx].ch));
                    last_ch = exp_q[rd_idx].ch;
                    rd_idx++;
                end else begin
                    check("out_ch_hold", 32'(out_ch_o), 32'(last_ch));
                end
                gv = (cyc >= m_gstart) && (cyc < m_gstart + NP);
                check("grant_vld", 32'(grant_vld_o), 32'(gv));
                check("grant", 32'(grant_o), gv ? (32'd1 << m_gch) : 32'd0);
                check("acc_clr", 32'(acc_clr_o), 32'(gv && cyc == m_gstart));
                if (gv) check("phase", 32'(phase_o), 32'(cyc - m_gstart));
                check("ovr_flag", 32'(ovr_flag_o), 32'(m_flag));
`ifdef HBF_SCHED_OVRCNT_EN
                for (int c = 0; c < NUM_CH; c++)
                    check("ovr_cnt", 32'(ovr_cnt_o[c*8 +: 8]), 32'(m_cnt[c]));
`endif
            end
        end
    end

    task automatic step(input logic [NUM_CH-1:0] r, input logic clr);
        req_i     = r;
        ovr_clr_i = clr;
        @(negedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"},     32'(grant_o),     32'd0);
        check({tag, "_grant_vld"}, 32'(grant_vld_o), 32'd0);
        check({tag, "_phase"},     32'(phase_o),     32'd0);
        check({tag, "_acc_clr"},   32'(acc_clr_o),   32'd0);
        check({tag, "_out_vld"},   32'(out_vld_o),   32'd0);
        check({tag, "_out_ch"},    32'(out_ch_o),    32'd0);
        check({tag, "_ovr_flag"},  32'(ovr_flag_o),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_ni  = 1'b0;
        req_i     = '0;
        ovr_clr_i = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk_i);
        #1 reset_ni = 1'b1;

        // All four channels at once: round-robin order from rr_ptr=0 is 1,2,3,0.
        step(4'b1111, 1'b0);
        idle(30);

        // Single request on channel 1.
        step(4'b0010, 1'b0);
        idle(12);

        // req[0] again on its grant edge: serviced twice, no overrun.
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        idle(20);
        check("same_edge_no_ovr", 32'(ovr_flag_o[0]), 32'd0);

        // Channel 3 requested twice while pending behind channel 0.
        step(4'b0001, 1'b0);
        step(4'b1000, 1'b0);
        idle(2);
        step(4'b1000, 1'b0);
        idle(30);
        check("ovr_flag3_set", 32'(ovr_flag_o[3]), 32'd1);
        step('0, 1'b1);
        check("ovr_flag_cleared", 32'(ovr_flag_o), 32'd0);
        idle(5);

        // Randomized traffic with occasional overrun clears.
        for (int i = 0; i < 3000; i++) begin
            logic [NUM_CH-1:0] r;
            for (int c = 0; c < NUM_CH; c++) r[c] = ($urandom_range(0, 19) == 0);
            step(r, $urandom_range(0, 49) == 0);
        end
        step('0, 1'b1);
        idle(40);

`ifdef HBF_SCHED_OVRCNT_EN
        for (int i = 0; i < 400; i++) step(4'b0100, 1'b0);
        check("ovr_cnt2_sat", 32'(ovr_cnt_o[23:16]), 32'd255);
        step('0, 1'b1);
        check("ovr_cnt2_clr", 32'(ovr_cnt_o[23:16]), 32'd0);
        idle(20);
`endif

        // Reset in the middle of a channel-2 MAC sequence.
        step(4'b0100, 1'b0);
        for (int i = 0; i < 10 && !grant_vld_o; i++) @(negedge clk_i);
        check("rst_wait_grant", 32'(grant_o), 32'b0100);
        @(posedge clk_i);
        #2 reset_ni = 1'b0;
        #1;
        check_all_zero("midrst");
        req_i = '0;
        ovr_clr_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1 reset_ni = 1'b1;
        idle(20);
        // rr_ptr back at 0: channel 2 must win over channel 0.
        step(4'b0101, 1'b0);
        idle(30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
